// File: rtl/muskbus_pkg.sv
// Shared Muskbus definitions: transaction tags, line geometry and a helper
// that turns a beat index into its bit offset inside an assembled line.
package MUSKBUS;

    localparam int TAG_WIDTH     = 8;
    localparam int BEAT_WIDTH    = 64;
    localparam int LINE_BEATS    = 8;
    localparam int LINE_BITS     = LINE_BEATS * BEAT_WIDTH;
    localparam int BEAT_IDX_BITS = $clog2(LINE_BEATS);
    localparam int BEAT_SHIFT    = $clog2(BEAT_WIDTH);
    localparam int OFFSET_BITS   = BEAT_IDX_BITS + BEAT_SHIFT;

    typedef logic [TAG_WIDTH-1:0] tag_t;

    localparam tag_t WRITE_MEM_TAG = 8'h01;
    localparam tag_t READ_MEM_TAG  = 8'h02;

    // Beat k of a line starts at bit k*BEAT_WIDTH; a shift keeps it a pure rewire.
    function automatic logic [OFFSET_BITS-1:0] beat_offset(input logic [BEAT_IDX_BITS-1:0] idx);
        return {idx, {BEAT_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/muskbus_if.sv
// Muskbus signal bundle. The Top modport is the initiator side: it bids,
// issues requests and acknowledges response beats.
interface Muskbus;
    import MUSKBUS::*;

    logic        bid;
    logic        reqcyc;
    tag_t        reqtag;
    logic [63:0] req;
    logic        reqack;
    logic        respcyc;
    tag_t        resptag;
    logic [63:0] resp;
    logic        respack;

    modport Top (
        output bid, reqcyc, reqtag, req, respack,
        input  reqack, respcyc, resptag, resp
    );

endinterface

// File: rtl/muskbus_reader.sv
// Muskbus line reader: bids for the bus, issues one READ_MEM_TAG request for
// a line address, collects eight 64-bit beats into a 512-bit line and hands
// the line back to the client with a one-cycle respcyc pulse.
module muskbus_reader
    import MUSKBUS::*;
(
    input  logic                 clk,
    input  logic                 reset,
    Muskbus.Top                  bus,
    input  logic                 reqcyc,
    input  logic [63:0]          addr,
    output logic                 respcyc,
    output logic [0:LINE_BITS-1] data
);

    typedef enum logic [1:0] {
        IDLE,
        REQUESTING,
        RECEIVING,
        DONE
    } state_t;

    state_t                   state_ff;
    state_t                   state_next;
    logic [BEAT_IDX_BITS-1:0] beat_ff;
    logic [63:0]              addr_ff;
    logic [0:LINE_BITS-1]     line_ff;
    logic                     beat_accept;

    // Bus drive, acknowledge and next state follow the current state and live bus inputs so the request and beat acks go out with zero latency.
    always_comb begin
        state_next  = state_ff;
        beat_accept = 1'b0;
        bus.bid     = 1'b0;
        bus.reqcyc  = 1'b0;
        bus.reqtag  = '0;
        bus.req     = '0;
        bus.respack = 1'b0;
        respcyc     = 1'b0;
        case (state_ff)
            IDLE: begin
                if (reqcyc) begin
                    bus.bid    = 1'b1;
                    bus.reqcyc = 1'b1;
                    bus.reqtag = READ_MEM_TAG;
                    bus.req    = addr;
                    state_next = bus.reqack ? RECEIVING : REQUESTING;
                end
            end
            REQUESTING: begin
                bus.bid    = 1'b1;
                bus.reqcyc = 1'b1;
                bus.reqtag = READ_MEM_TAG;
                bus.req    = addr_ff;
                if (bus.reqack) begin
                    state_next = RECEIVING;
                end
            end
            RECEIVING: begin
                bus.bid     = 1'b1;
                beat_accept = bus.respcyc && (bus.resptag == READ_MEM_TAG);
                bus.respack = beat_accept;
                if (beat_accept && (beat_ff == BEAT_IDX_BITS'(LINE_BEATS - 1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                respcyc    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, captured address, beat counter and line assembly; reset aborts any read in flight and discards the partial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_ff <= IDLE;
            beat_ff  <= '0;
            addr_ff  <= '0;
            line_ff  <= '0;
        end else begin
            state_ff <= state_next;
            case (state_ff)
                IDLE: begin
                    if (reqcyc) begin
                        addr_ff <= addr;
                        if (bus.reqack) begin
                            beat_ff <= '0;
                        end
                    end
                end
                REQUESTING: begin
                    if (bus.reqack) begin
                        beat_ff <= '0;
                    end
                end
                RECEIVING: begin
                    if (beat_accept) begin
                        line_ff[beat_offset(beat_ff) +: BEAT_WIDTH] <= bus.resp;
                        beat_ff <= beat_ff + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data = line_ff;

endmodule
